// File: rtl/clk_div_pwm_if.sv
// rtl/clk_div_pwm_if.sv - control and status bundle for the programmable divider/PWM
interface clk_div_pwm_if #(
    parameter int CNT_W = 22
);
    logic             en;
    logic             load;
    logic [1:0]       mode;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] cnt;
    logic             out;
    logic             tick;
    logic             pend;

    modport master (
        output en, load, mode, period, duty,
        input  cnt, out, tick, pend
    );

    modport slave (
        input  en, load, mode, period, duty,
        output cnt, out, tick, pend
    );
endinterface

// File: rtl/clk_div_pwm.sv
// rtl/clk_div_pwm.sv - period counter with double-buffered toggle/pulse/PWM output
module clk_div_pwm #(
    parameter int CNT_W          = 22,
    parameter int DEFAULT_PERIOD = 2499999
) (
    input  logic          clk,
    input  logic          rst_n,
    clk_div_pwm_if.slave  bus
);
    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] DEF_D = CNT_W'((DEFAULT_PERIOD + 1) / 2);

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_PULSE  = 2'b01;
    localparam logic [1:0] MODE_PWM    = 2'b10;

    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_tick;
    logic             r_pend;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_duty;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_pend_per;
    logic [CNT_W-1:0] r_pend_duty;
    logic [1:0]       r_pend_mode;

    logic             w_wrap;
    logic             w_swap;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_eff_mode;
    logic [CNT_W-1:0] w_eff_duty;

    assign w_wrap     = (r_cnt == r_per);
    assign w_cnt_next = w_wrap ? '0 : r_cnt + CNT_W'(1);
    // A settings swap at a wrap must already govern the output computed on that edge.
    assign w_swap     = w_wrap && r_pend;
    assign w_eff_mode = w_swap ? r_pend_mode : r_mode;
    assign w_eff_duty = w_swap ? r_pend_duty : r_duty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_out       <= 1'b0;
            r_tick      <= 1'b0;
            r_pend      <= 1'b0;
            r_per       <= DEF_P;
            r_duty      <= DEF_D;
            r_mode      <= MODE_TOGGLE;
            r_pend_per  <= '0;
            r_pend_duty <= '0;
            r_pend_mode <= MODE_TOGGLE;
        end else if (bus.en) begin
            r_cnt  <= w_cnt_next;
            r_tick <= w_wrap;
            if (w_swap) begin
                r_per  <= r_pend_per;
                r_duty <= r_pend_duty;
                r_mode <= r_pend_mode;
            end
            case (w_eff_mode)
                MODE_TOGGLE: if (w_wrap) r_out <= ~r_out;
                MODE_PULSE:  r_out <= w_wrap;
                MODE_PWM:    r_out <= (w_cnt_next < w_eff_duty);
                default:     r_out <= 1'b0;
            endcase
            // A load coinciding with a wrap queues behind the swap happening on that edge.
            if (bus.load) begin
                r_pend_per  <= bus.period;
                r_pend_duty <= bus.duty;
                r_pend_mode <= bus.mode;
                r_pend      <= 1'b1;
            end else if (w_wrap) begin
                r_pend      <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
            if (bus.load) begin
                r_per  <= bus.period;
                r_duty <= bus.duty;
                r_mode <= bus.mode;
                r_cnt  <= '0;
                r_pend <= 1'b0;
            end
        end
    end

    assign bus.cnt  = r_cnt;
    assign bus.out  = r_out;
    assign bus.tick = r_tick;
    assign bus.pend = r_pend;
endmodule

// File: tb/tb_clk_div_pwm.sv
// tb/tb_clk_div_pwm.sv - scoreboard bench for clk_div_pwm with directed vectors
module tb_clk_div_pwm;
    localparam int CNT_W = 22;
    localparam int DEFP  = 49;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc_num = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;

    typedef struct {
        int              cyc;
        logic [CNT_W-1:0] cnt;
        logic            o;
        logic            t;
        logic            p;
    } exp_t;

    exp_t sb[$];

    clk_div_pwm_if #(.CNT_W(CNT_W)) bus ();

    clk_div_pwm #(.CNT_W(CNT_W), .DEFAULT_PERIOD(DEFP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_num = cyc_num + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk = n_chk + 1;
        if (act != exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc_num, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc_num) begin
            exp_t e;
            e = sb.pop_front();
            chk("cnt",  int'(bus.cnt),  int'(e.cnt));
            chk("out",  int'(bus.out),  int'(e.o));
            chk("tick", int'(bus.tick), int'(e.t));
            chk("pend", int'(bus.pend), int'(e.p));
        end
    end

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic cyc(input int rs, input int en_v, input int ld, input int md,
                       input int per, input int dty,
                       input int ecnt, input int eout, input int etick, input int epend);
        exp_t e;
        rst_n      = rs[0];
        bus.en     = en_v[0];
        bus.load   = ld[0];
        bus.mode   = md[1:0];
        bus.period = CNT_W'(per);
        bus.duty   = CNT_W'(dty);
        e.cyc = cyc_num + 1;
        e.cnt = CNT_W'(ecnt);
        e.o   = eout[0];
        e.t   = etick[0];
        e.p   = epend[0];
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset overrides en/load
        for (int k = 0; k < 3; k++) cyc(0, 1, 1, 2, 5, 2, 0, 0, 0, 0);
        // default period DEFP: first wrap after DEFP+1 cycles
        for (int k = 1; k <= 52; k++) cyc(1, 1, 0, 0, 0, 0, k % 50, k >= 50, (k % 50) == 0, 0);

        // TOGGLE P=3, out starts at 1
        cyc(1, 0, 1, 0, 3, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 16; k++) cyc(1, 1, 0, 0, 0, 0, k % 4, 1 ^ ((k / 4) & 1), (k % 4) == 0, 0);
        // TOGGLE P=0
        cyc(1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 6; k++) cyc(1, 1, 0, 0, 0, 0, 0, 1 ^ (k & 1), 1, 0);

        // PULSE P=9
        cyc(1, 0, 1, 1, 9, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 20; k++) cyc(1, 1, 0, 0, 0, 0, k % 10, (k % 10) == 0, (k % 10) == 0, 0);
        // PWM P=9 D=3
        cyc(1, 0, 1, 2, 9, 3, 0, 1, 0, 0);
        for (int k = 1; k <= 20; k++) cyc(1, 1, 0, 0, 0, 0, k % 10, (k % 10) < 3, (k % 10) == 0, 0);
        // PWM D=0
        cyc(1, 0, 1, 2, 9, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 10; k++) cyc(1, 1, 0, 0, 0, 0, k % 10, 0, (k % 10) == 0, 0);
        // PWM D=P+1
        cyc(1, 0, 1, 2, 9, 10, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) cyc(1, 1, 0, 0, 0, 0, k % 10, 1, (k % 10) == 0, 0);

        // shadow update: P=9 D=3 running, load P=4 D=2 at cnt=4
        cyc(1, 0, 1, 2, 9, 3, 0, 1, 0, 0);
        for (int k = 1; k <= 4; k++) cyc(1, 1, 0, 0, 0, 0, k, k < 3, 0, 0);
        cyc(1, 1, 1, 2, 4, 2, 5, 0, 0, 1);
        for (int j = 6; j <= 9; j++) cyc(1, 1, 0, 0, 0, 0, j, 0, 0, 1);
        for (int m = 0; m <= 9; m++) cyc(1, 1, 0, 0, 0, 0, m % 5, (m % 5) < 2, (m % 5) == 0, 0);
        // load on a wrap edge, then a second load: only the second applies
        cyc(1, 1, 1, 2, 7, 1, 0, 1, 1, 1);
        cyc(1, 1, 1, 2, 5, 4, 1, 1, 0, 1);
        for (int j = 2; j <= 4; j++) cyc(1, 1, 0, 0, 0, 0, j, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        for (int m = 1; m <= 12; m++) cyc(1, 1, 0, 0, 0, 0, m % 6, (m % 6) < 4, (m % 6) == 0, 0);

        // enable freeze right after a wrap
        for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 2, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 4, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 5, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 1, 0);

        // reset with pend=1 and out=1 discards the pending update
        cyc(1, 1, 1, 0, 2, 1, 1, 1, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 51; k++) cyc(1, 1, 0, 0, 0, 0, k % 50, k >= 50, (k % 50) == 0, 0);

        @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
